fifo_burst_reader: RTL and testbench
====================================

# fifo_burst_reader

- Read-side consumer for the FIFO controller/register-file pair.
- Accepts a burst command of N words, pops exactly N entries via the FIFO's `rd`/`empty` interface, and delivers them on a registered valid/ready stream with a last-beat marker.
- Sits between the FIFO and any downstream consumer (UART TX, display engine).
- Sustains one word per cycle when the FIFO is non-empty and downstream is ready.

## Interface
- DATA_WIDTH, 8, width of FIFO and stream data
- LEN_WIDTH, 8, width of burst length; max burst 2^LEN_WIDTH-1 words
- TIMEOUT_CYCLES, 255, empty-stall watchdog limit (used only with FIFO_RD_TIMEOUT_EN)
- clk  input  1  single clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- cmd_valid  input  1  burst command present
- cmd_len  input  LEN_WIDTH  number of words to read
- cmd_ready  output  1  block idle, command accepted when cmd_valid && cmd_ready
- empty  input  1  FIFO empty flag
- r_data  input  DATA_WIDTH  FIFO head word (combinational read at current r_addr)
- rd  output  1  pop strobe to FIFO controller
- m_valid  output  1  stream word valid
- m_data  output  DATA_WIDTH  stream word
- m_last  output  1  final word of burst
- m_ready  input  1  downstream accepts word
- done  output  1  one-cycle pulse at burst completion
- err  output  1  burst aborted by watchdog (with done only)

## Operation
- States: IDLE, BURST, DRAIN. Reset state IDLE.
- IDLE: cmd_ready=1. On accept, load remaining=cmd_len. If cmd_len=0, go straight to IDLE next cycle with done=1; rd is never asserted. Otherwise go to BURST.
- BURST: rd = ~empty && (remaining!=0) && (~m_valid || m_ready). rd is never asserted while empty=1.
- On rd:
  - m_data<=r_data, m_valid<=1, remaining<=remaining-1.
  - m_last<=1 when remaining==1.
  - When remaining reaches 0, go to DRAIN.
- A beat completes on m_valid && m_ready. If no new rd occurs in that cycle, m_valid<=0.
- m_data, m_last, m_valid are held stable while m_valid && ~m_ready.
- DRAIN: wait for the beat with m_last=1 to be accepted. In that cycle go to IDLE and register done=1 for the next cycle; m_valid/m_last clear.
- Simultaneous accept of beat k and pop of beat k+1 in the same cycle is required; throughput is 1 word/cycle.
- Commands arriving while not IDLE are ignored (cmd_ready=0).
- remaining is LEN_WIDTH bits. It decrements only on rd and never wraps below 0.

## Timing
- Reset values: cmd_ready=1, rd=0, m_valid=0, m_data=0, m_last=0, done=0, err=0, remaining=0.
- Reset asserted mid-burst aborts immediately: outputs go to reset values asynchronously, no further rd, and no done pulse.
- Command accepted at cycle T: state BURST at T+1; earliest rd at T+1; earliest m_valid at T+2.
- rd is combinational from state, remaining, empty, m_valid and m_ready. All other outputs are registered.
- done is asserted exactly one cycle after the final beat handshake and lasts one cycle. cmd_ready rises in that same cycle, so a new command can be accepted there.
- len=0: done at T+1, no stream activity.

## Configuration
- FIFO_RD_TIMEOUT_EN defined:
  - In BURST, a stall counter counts cycles with empty=1 and remaining!=0, and resets on any rd.
  - When it reaches TIMEOUT_CYCLES, the burst aborts. Any held word still drains normally, but m_last is not forced.
  - The block then returns to IDLE with done=1 and err=1 in the same cycle.
- Not defined: no counter; err tied 0; the block waits indefinitely for data.

## Structure
- Shared package `fifo_pkg`: state encoding constants (IDLE/BURST/DRAIN) and the default DATA_WIDTH/LEN_WIDTH values, shared with the FIFO controller.
- One sub-module: `stream_out_reg`, the output register holding m_data/m_last/m_valid. It has load and accept inputs and reports "free" as ~m_valid || m_ready.
- The FSM, remaining counter and watchdog stay in the top module.

## Test plan
- cmd_len=4, FIFO preloaded 0x11..0x44, m_ready=1: rd high T+1..T+4; m_data 0x11,0x22,0x33,0x44 at T+2..T+5; m_last only on 0x44; done at T+6.
- Backpressure: cmd_len=3 with m_ready low for 3 cycles after the first beat: m_data and m_valid held stable, no rd while held, no lost or duplicated word.
- FIFO goes empty mid-burst for 5 cycles (cmd_len=6): rd stays 0 while empty=1; the burst resumes and delivers all 6 words in order.
- cmd_len=0: done pulses at T+1; rd and m_valid stay 0 throughout.
- Reset asserted after 2 of 5 words: all outputs at reset values within the reset cycle; after release, cmd_ready=1 and no done pulse.
- With FIFO_RD_TIMEOUT_EN, TIMEOUT_CYCLES=8, cmd_len=4, FIFO holding only 2 words: 2 beats delivered, then done=1 and err=1 exactly 8 stall cycles later.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: definitions shared by the FIFO controller and the burst reader.
//   - Default DATA_WIDTH / LEN_WIDTH values.
//   - Burst reader state encoding (idle, burst, drain).
package fifo_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 8;
   localparam int unsigned DEF_LEN_WIDTH  = 8;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StBurst = 2'd1,
      StDrain = 2'd2
   } state_e;

endpackage

// File: rtl/stream_out_reg.sv
// stream_out_reg: registered valid/ready output stage of the burst reader.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   load                  capture load_data/load_last and raise m_valid
//   load_data, load_last  word and last-beat marker to capture
//   accept                downstream ready (m_ready)
//   m_valid/m_data/m_last registered stream outputs
//   free                  stage can take a new word this cycle (~m_valid || accept)
module stream_out_reg #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  load_last,
   input  logic                  accept,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic                  free
);

   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  last_q, last_d;

   assign free = ~valid_q | accept;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      last_d  = last_q;
      if (load) begin
         // A load may coincide with acceptance of the held word.
         valid_d = 1'b1;
         data_d  = load_data;
         last_d  = load_last;
      end else if (valid_q && accept) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   assign m_valid = valid_q;
   assign m_data  = data_q;
   assign m_last  = last_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops a commanded number of words from a FIFO and streams them out.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   cmd_valid, cmd_len, cmd_ready burst command (accepted while idle)
//   empty, r_data, rd            FIFO read interface (rd is combinational)
//   m_valid, m_data, m_last, m_ready  output stream with last-beat marker
//   done, err                    completion pulse; err flags a watchdog abort
// Build option: define FIFO_RD_TIMEOUT_EN to enable the empty-stall watchdog
// (TIMEOUT_CYCLES); otherwise err is tied low and the reader waits indefinitely.
module fifo_burst_reader
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int unsigned LEN_WIDTH      = DEF_LEN_WIDTH,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  cmd_valid,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   output logic                  cmd_ready,
   input  logic                  empty,
   input  logic [DATA_WIDTH-1:0] r_data,
   output logic                  rd,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   input  logic                  m_ready,
   output logic                  done,
   output logic                  err
);

   // A zero limit would make the watchdog compare wrap.
   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be non-zero");
   end

   state_e               state_q, state_d;
   logic [LEN_WIDTH-1:0] rem_q, rem_d;
   logic                 done_q, done_d;
   logic                 rd_en;
   logic                 free;
   logic                 last_word;
   logic                 drain_abort;

   assign last_word = (rem_q == LEN_WIDTH'(1));
   assign rd_en     = (state_q == StBurst) && !empty && (rem_q != '0) && free;
   assign rd        = rd_en;
   assign cmd_ready = (state_q == StIdle);
   assign done      = done_q;

`ifdef FIFO_RD_TIMEOUT_EN
   localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [STALL_W-1:0] stall_q, stall_d;
   logic               stalling;
   logic               stall_hit;
   logic               abort_q, abort_d;
   logic               err_q, err_d;

   assign stalling  = (state_q == StBurst) && empty && (rem_q != '0);
   // Fires on the TIMEOUT_CYCLES-th consecutive stall cycle.
   assign stall_hit = stalling && (stall_q == STALL_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      stall_d = stall_q;
      if ((state_q != StBurst) || rd_en) begin
         stall_d = '0;
      end else if (stalling) begin
         stall_d = stall_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_q <= '0;
         abort_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         stall_q <= stall_d;
         abort_q <= abort_d;
         err_q   <= err_d;
      end
   end

   // An aborted burst leaves its held word without m_last; drain it anyway.
   assign drain_abort = abort_q;
   assign err         = err_q;
`else
   assign drain_abort = 1'b0;
   assign err         = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
`ifdef FIFO_RD_TIMEOUT_EN
      err_d   = 1'b0;
      abort_d = abort_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               if (cmd_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  rem_d   = cmd_len;
                  state_d = StBurst;
               end
            end
         end
         StBurst: begin
            if (rd_en) begin
               rem_d = rem_q - 1'b1;
               if (last_word) begin
                  state_d = StDrain;
               end
            end
`ifdef FIFO_RD_TIMEOUT_EN
            else if (stall_hit) begin
               if (free) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else begin
                  state_d = StDrain;
                  abort_d = 1'b1;
               end
            end
`endif
         end
         StDrain: begin
            if (m_valid && m_ready && (m_last || drain_abort)) begin
               state_d = StIdle;
               done_d  = 1'b1;
`ifdef FIFO_RD_TIMEOUT_EN
               err_d   = abort_q;
               abort_d = 1'b0;
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         rem_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         done_q  <= done_d;
      end
   end

   stream_out_reg #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_stream_out_reg (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (rd_en),
      .load_data (r_data),
      .load_last (last_word),
      .accept    (m_ready),
      .m_valid   (m_valid),
      .m_data    (m_data),
      .m_last    (m_last),
      .free      (free)
   );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a small FIFO model in front.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_fifo_burst_reader;

   localparam int unsigned DW = 8;
   localparam int unsigned LW = 8;
`ifdef FIFO_RD_TIMEOUT_EN
   localparam int unsigned TO = 8;
`else
   localparam int unsigned TO = 255;
`endif

   logic          clk = 1'b0;
   logic          reset_n;
   logic          cmd_valid;
   logic [LW-1:0] cmd_len;
   logic          cmd_ready;
   logic          empty;
   logic [DW-1:0] r_data;
   logic          rd;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic          m_ready;
   logic          done;
   logic          err;

   always #5 clk = ~clk;

   fifo_burst_reader #(
      .DATA_WIDTH     (DW),
      .LEN_WIDTH      (LW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cmd_valid (cmd_valid),
      .cmd_len   (cmd_len),
      .cmd_ready (cmd_ready),
      .empty     (empty),
      .r_data    (r_data),
      .rd        (rd),
      .m_valid   (m_valid),
      .m_data    (m_data),
      .m_last    (m_last),
      .m_ready   (m_ready),
      .done      (done),
      .err       (err)
   );

   // FIFO model: push from the stimulus process, pop on rd.
   logic [DW-1:0] mem [16];
   logic [31:0]   rd_ptr = 0;
   logic [31:0]   wr_ptr = 0;
   logic          hold = 1'b0;

   assign empty  = hold || (rd_ptr == wr_ptr);
   assign r_data = mem[rd_ptr[3:0]];

   always @(posedge clk) begin
      if (rd && !empty) rd_ptr <= rd_ptr + 1;
   end

   // Beat capture and protocol monitors.
   logic [DW-1:0] beat_data [64];
   logic          beat_last [64];
   logic [31:0]   nb = 0;
   int            done_cnt = 0;
   int            rd_empty_viol = 0;

   always @(posedge clk) begin
      if (reset_n && m_valid && m_ready) begin
         beat_data[nb[5:0]] <= m_data;
         beat_last[nb[5:0]] <= m_last;
         nb <= nb + 1;
      end
      if (reset_n && done) done_cnt <= done_cnt + 1;
      if (rd && empty) rd_empty_viol <= rd_empty_viol + 1;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic push(input logic [DW-1:0] v);
      mem[wr_ptr[3:0]] = v;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic send_cmd(input logic [LW-1:0] len);
      tick();
      cmd_valid = 1'b1;
      cmd_len   = len;
      #1;
      check("cmd_ready at accept", cmd_ready, 1);
   endtask

   logic [31:0] base;
   int          done_base;
   logic        seen_done;

   initial begin
      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      cmd_len   = '0;
      m_ready   = 1'b1;
      #1;
      check("rst cmd_ready", cmd_ready, 1);
      check("rst rd", rd, 0);
      check("rst m_valid", m_valid, 0);
      check("rst m_data", m_data, 0);
      check("rst m_last", m_last, 0);
      check("rst done", done, 0);
      check("rst err", err, 0);
      tick();
      tick();
      reset_n = 1'b1;

      // 1: len 4, FIFO 11..44, always ready.
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      base = nb;
      send_cmd(8'd4);
      for (int k = 1; k <= 6; k++) begin
         tick();
         cmd_valid = 1'b0;
         #1;
         check($sformatf("t1 rd k=%0d", k), rd, (k <= 4) ? 1 : 0);
         check($sformatf("t1 m_valid k=%0d", k), m_valid, (k >= 2 && k <= 5) ? 1 : 0);
         if (k >= 2 && k <= 5) check($sformatf("t1 m_data k=%0d", k), m_data, (k - 1) * 8'h11);
         check($sformatf("t1 m_last k=%0d", k), m_last, (k == 5) ? 1 : 0);
         check($sformatf("t1 done k=%0d", k), done, (k == 6) ? 1 : 0);
         check($sformatf("t1 cmd_ready k=%0d", k), cmd_ready, (k == 6) ? 1 : 0);
         check($sformatf("t1 err k=%0d", k), err, 0);
      end
      tick();
      #1;
      check("t1 done one cycle", done, 0);
      check("t1 beats", nb - base, 4);

      // 2: len 3 with three cycles of backpressure on the second word.
      push(8'hAA); push(8'hBB); push(8'hCC);
      base = nb;
      send_cmd(8'd3);
      tick(); cmd_valid = 1'b0; #1;
      check("t2 rd T+1", rd, 1);
      tick(); #1;
      check("t2 data T+2", m_data, 8'hAA);
      check("t2 rd T+2", rd, 1);
      for (int k = 3; k <= 5; k++) begin
         tick();
         m_ready = 1'b0;
         #1;
         check($sformatf("t2 held valid k=%0d", k), m_valid, 1);
         check($sformatf("t2 held data k=%0d", k), m_data, 8'hBB);
         check($sformatf("t2 held last k=%0d", k), m_last, 0);
         check($sformatf("t2 no rd k=%0d", k), rd, 0);
      end
      tick(); m_ready = 1'b1; #1;
      check("t2 data T+6", m_data, 8'hBB);
      check("t2 rd T+6", rd, 1);
      tick(); #1;
      check("t2 data T+7", m_data, 8'hCC);
      check("t2 last T+7", m_last, 1);
      check("t2 rd T+7", rd, 0);
      tick(); #1;
      check("t2 done T+8", done, 1);
      check("t2 beats", nb - base, 3);
      check("t2 beat0", beat_data[base[5:0]], 8'hAA);
      check("t2 beat1", beat_data[base[5:0] + 6'd1], 8'hBB);
      check("t2 beat2", beat_data[base[5:0] + 6'd2], 8'hCC);
      check("t2 last2", beat_last[base[5:0] + 6'd2], 1);

      // 3: len 6 with the FIFO reporting empty for 5 cycles after two pops.
      for (int i = 1; i <= 6; i++) push(i[7:0]);
      base = nb;
      send_cmd(8'd6);
      tick(); cmd_valid = 1'b0; #1;
      check("t3 rd T+1", rd, 1);
      tick(); #1;
      check("t3 rd T+2", rd, 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         hold = 1'b1;
         #1;
         check($sformatf("t3 rd while empty i=%0d", i), rd, 0);
      end
      tick(); hold = 1'b0; #1;
      check("t3 rd resumes", rd, 1);
      seen_done = 1'b0;
      for (int i = 0; i < 20 && !seen_done; i++) begin
         tick(); #1;
         if (done) seen_done = 1'b1;
      end
      check("t3 done seen", seen_done, 1);
      check("t3 beats", nb - base, 6);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("t3 beat%0d", i), beat_data[base[5:0] + i[5:0]], i + 1);
         check($sformatf("t3 last%0d", i), beat_last[base[5:0] + i[5:0]], (i == 5) ? 1 : 0);
      end

      // 4: zero-length command.
      base = nb;
      tick();
      cmd_valid = 1'b1;
      cmd_len   = 8'd0;
      #1;
      check("t4 rd T", rd, 0);
      tick(); cmd_valid = 1'b0; #1;
      check("t4 done T+1", done, 1);
      check("t4 rd T+1", rd, 0);
      check("t4 m_valid T+1", m_valid, 0);
      check("t4 cmd_ready T+1", cmd_ready, 1);
      tick(); #1;
      check("t4 done T+2", done, 0);
      check("t4 m_valid T+2", m_valid, 0);
      check("t4 no beats", nb - base, 0);

      // 5: reset after two of five words.
      for (int i = 1; i <= 5; i++) push(8'h60 + i[7:0]);
      base = nb;
      send_cmd(8'd5);
      tick(); cmd_valid = 1'b0;
      tick();
      tick();
      tick();
      #1;
      check("t5 third word pending", m_data, 8'h63);
      done_base = done_cnt;
      reset_n = 1'b0;
      #1;
      check("t5 rst cmd_ready", cmd_ready, 1);
      check("t5 rst rd", rd, 0);
      check("t5 rst m_valid", m_valid, 0);
      check("t5 rst m_data", m_data, 0);
      check("t5 rst m_last", m_last, 0);
      check("t5 rst done", done, 0);
      check("t5 beats before reset", nb - base, 2);
      tick(); reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick(); #1;
         check($sformatf("t5 post cmd_ready i=%0d", i), cmd_ready, 1);
         check($sformatf("t5 post rd i=%0d", i), rd, 0);
      end
      check("t5 no done pulse", done_cnt - done_base, 0);
      wr_ptr = rd_ptr;

`ifdef FIFO_RD_TIMEOUT_EN
      // 6: watchdog with only two words available for a four-word burst.
      push(8'h5A); push(8'hA5);
      base = nb;
      send_cmd(8'd4);
      tick(); cmd_valid = 1'b0;
      for (int k = 2; k <= 11; k++) begin
         tick(); #1;
         check($sformatf("t6 done k=%0d", k), done, (k == 11) ? 1 : 0);
         check($sformatf("t6 err k=%0d", k), err, (k == 11) ? 1 : 0);
      end
      check("t6 cmd_ready", cmd_ready, 1);
      check("t6 beats", nb - base, 2);
      tick(); #1;
      check("t6 err one cycle", err, 0);
`endif

      check("rd never while empty", rd_empty_viol, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
